// File: rtl/servo_pkg.sv
// Shared types and defaults for the servo setpoint path and the per-axis
// PWM comparators that consume cntr_val / x_val.
//   slew_toward   : one period's worth of movement of x toward a target
//   clamp_sample  : raw 10-bit sample -> pulse-width setpoint
package servo_pkg;
  localparam int CLK_DIV    = 100;   // clk per counter tick (1 us at 100 MHz)
  localparam int PERIOD_CNT = 3000;  // counter modulus (3 ms)
  localparam int MIN_PULSE  = 1000;
  localparam int MAX_IN     = 1000;
  localparam int CENTER     = 1500;
  localparam int SLEW_STEP  = 50;

  localparam int CNTR_W   = 12;
  localparam int SETPT_W  = 11;
  localparam int SAMPLE_W = 10;

  typedef logic [CNTR_W-1:0]   cntr_t;
  typedef logic [SETPT_W-1:0]  setpt_t;
  typedef logic [SAMPLE_W-1:0] sample_t;

  // Saturate at MAX_IN before the offset so the sum always fits in 11 bits.
  function automatic setpt_t clamp_sample(sample_t d);
    if (d > SAMPLE_W'(MAX_IN)) return setpt_t'(MIN_PULSE + MAX_IN);
    return setpt_t'({1'b0, d}) + setpt_t'(MIN_PULSE);
  endfunction

  // Difference taken one bit wider and signed so both directions share a compare.
  function automatic setpt_t slew_toward(setpt_t tgt, setpt_t cur);
    logic signed [CNTR_W-1:0] diff;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    if (diff > $signed(CNTR_W'(SLEW_STEP)))  return cur + setpt_t'(SLEW_STEP);
    if (diff < -$signed(CNTR_W'(SLEW_STEP))) return cur - setpt_t'(SLEW_STEP);
    return tgt;
  endfunction
endpackage

// File: rtl/servo_setpoint_if.sv
// Sample intake handshake plus the timebase/setpoint outputs.
//   master : sample source / observer (drives valid+data)
//   slave  : servo_setpoint_timebase
interface servo_setpoint_if;
  import servo_pkg::*;
  logic    sample_valid;
  sample_t sample_data;
  logic    sample_ready;
  cntr_t   cntr_val;
  setpt_t  x_val;
  logic    period_start;

  modport master (output sample_valid, sample_data,
                  input  sample_ready, cntr_val, x_val, period_start);
  modport slave  (input  sample_valid, sample_data,
                  output sample_ready, cntr_val, x_val, period_start);
endinterface

// File: rtl/servo_timebase.sv
// Shared PWM timebase: prescaler -> period counter 0..PERIOD_CNT-1.
//   clk, rst       : clock, async active-high reset
//   cntr_o         : period counter
//   period_start_o : one clk high right after the counter wraps to 0
module servo_timebase #(
  parameter int CLK_DIV    = servo_pkg::CLK_DIV,
  parameter int PERIOD_CNT = servo_pkg::PERIOD_CNT
) (
  input  logic             clk,
  input  logic             rst,
  output servo_pkg::cntr_t cntr_o,
  output logic             period_start_o
);
  import servo_pkg::*;

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [PW-1:0] presc_q, presc_d;
  cntr_t         cntr_q, cntr_d;
  logic          pstart_q, pstart_d;
  logic          tick;

  assign tick = (presc_q == PW'(CLK_DIV - 1));

  always_comb begin
    presc_d  = presc_q + PW'(1);
    cntr_d   = cntr_q;
    pstart_d = 1'b0;
    if (tick) begin
      presc_d = '0;
      if (cntr_q == cntr_t'(PERIOD_CNT - 1)) begin
        cntr_d   = '0;
        pstart_d = 1'b1;   // lands together with cntr==0
      end else begin
        cntr_d = cntr_q + cntr_t'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q  <= '0;
      cntr_q   <= '0;
      pstart_q <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      cntr_q   <= cntr_d;
      pstart_q <= pstart_d;
    end
  end

  assign cntr_o         = cntr_q;
  assign period_start_o = pstart_q;
endmodule

// File: rtl/servo_setpoint_timebase.sv
// Timebase + slew-limited pulse-width setpoint for one servo axis.
//   clk, rst : clock, async active-high reset
//   bus      : sample valid/ready intake, cntr_val, x_val, period_start
// A sample is parked in a one-deep pending slot, promoted to target on a
// period boundary, and x_val walks toward the previous target by at most
// SLEW_STEP per period, only while cntr_val==0 so the comparator never glitches.
module servo_setpoint_timebase #(
  parameter int CLK_DIV    = servo_pkg::CLK_DIV,
  parameter int PERIOD_CNT = servo_pkg::PERIOD_CNT
) (
  input  logic              clk,
  input  logic              rst,
  servo_setpoint_if.slave   bus
);
  import servo_pkg::*;

  cntr_t  cntr;
  logic   pstart;
  setpt_t pending_q, pending_d;
  logic   full_q, full_d;
  setpt_t target_q, target_d;
  setpt_t x_q, x_d;
  logic   accept;

  servo_timebase #(.CLK_DIV(CLK_DIV), .PERIOD_CNT(PERIOD_CNT)) u_tb (
    .clk            (clk),
    .rst            (rst),
    .cntr_o         (cntr),
    .period_start_o (pstart)
  );

  assign accept = bus.sample_valid && !full_q;

  always_comb begin
    pending_d = pending_q;
    full_d    = full_q;
    target_d  = target_q;
    x_d       = x_q;
    // accept needs full_q==0 and promotion needs full_q==1: never both.
    if (accept) begin
      pending_d = clamp_sample(bus.sample_data);
      full_d    = 1'b1;
    end
    if (pstart) begin
      x_d = slew_toward(target_q, x_q);   // steps toward the old target
      if (full_q) begin
        target_d = pending_q;
        full_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= setpt_t'(CENTER);
      full_q    <= 1'b0;
      target_q  <= setpt_t'(CENTER);
      x_q       <= setpt_t'(CENTER);
    end else begin
      pending_q <= pending_d;
      full_q    <= full_d;
      target_q  <= target_d;
      x_q       <= x_d;
    end
  end

  assign bus.sample_ready = !full_q;
  assign bus.cntr_val     = cntr;
  assign bus.x_val        = x_q;
  assign bus.period_start = pstart;
endmodule

// File: tb/tb_servo_setpoint_timebase.sv
// Directed bench for servo_setpoint_timebase with a shortened timebase
// (4 clk/tick, 20 ticks/period -> 80 clk period).
module tb_servo_setpoint_timebase;
  localparam int CD  = 4;
  localparam int PC  = 20;
  localparam int PER = CD * PC;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  servo_setpoint_if bus();

  servo_setpoint_timebase #(.CLK_DIV(CD), .PERIOD_CNT(PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit         send;
    logic [9:0] data;
    int         exp_x;   // x_val right after the next boundary
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Stops at the negedge where period_start is seen high; n = negedges waited.
  task automatic wait_pstart(output int n);
    bit got;
    got = 1'b0;
    n = 0;
    while (!got && n < 4 * PER) begin
      @(negedge clk);
      n++;
      if (bus.period_start === 1'b1) got = 1'b1;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL boundary_timeout: got none expected period_start within %0d clk", 4 * PER);
    end
  endtask

  task automatic boundary_then_x(input string nm, input int exp);
    int n;
    wait_pstart(n);
    @(negedge clk);
    chk(nm, int'(bus.x_val), exp);
  endtask

  // One-cycle offer while ready is high; accepted on the following posedge.
  task automatic send(input logic [9:0] d);
    bus.sample_valid = 1'b1;
    bus.sample_data  = d;
    @(negedge clk);
    bus.sample_valid = 1'b0;
    chk("ready_low_after_accept", int'(bus.sample_ready), 0);
  endtask

  task automatic async_reset_check(input string nm);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk({nm, "_cntr"},   int'(bus.cntr_val), 0);
    chk({nm, "_x"},      int'(bus.x_val), 1500);
    chk({nm, "_ready"},  int'(bus.sample_ready), 1);
    chk({nm, "_pstart"}, int'(bus.period_start), 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int n, highs;
    bus.sample_valid = 1'b0;
    bus.sample_data  = '0;

    // table: clamp+slew up, slew down, partial steps both ways
    tbl.push_back('{1'b1, 10'd1023, 1500});
    for (int k = 1; k <= 10; k++) tbl.push_back('{1'b0, 10'd0, 1500 + 50 * k});
    tbl.push_back('{1'b0, 10'd0, 2000});
    tbl.push_back('{1'b1, 10'd0, 2000});
    for (int k = 1; k <= 20; k++) tbl.push_back('{1'b0, 10'd0, 2000 - 50 * k});
    tbl.push_back('{1'b0, 10'd0, 1000});
    tbl.push_back('{1'b1, 10'd30, 1000});
    tbl.push_back('{1'b0, 10'd0, 1030});
    tbl.push_back('{1'b0, 10'd0, 1030});
    tbl.push_back('{1'b1, 10'd1000, 1030});
    for (int k = 1; k <= 19; k++) tbl.push_back('{1'b0, 10'd0, 1030 + 50 * k});
    tbl.push_back('{1'b0, 10'd0, 2000});
    tbl.push_back('{1'b0, 10'd0, 2000});

    repeat (7) @(negedge clk);
    async_reset_check("reset");

    // timebase from release: tick every CD clk, wrap to 0 with period_start
    highs = 0;
    for (int c = 1; c <= 2 * PER + 1; c++) begin
      @(negedge clk);
      if (bus.period_start === 1'b1) highs++;
      if (c == CD - 1)  chk("cntr_before_tick", int'(bus.cntr_val), 0);
      if (c == CD)      chk("cntr_first_tick", int'(bus.cntr_val), 1);
      if (c == PER - 1) chk("cntr_max", int'(bus.cntr_val), PC - 1);
      if (c == PER) begin
        chk("cntr_wrap", int'(bus.cntr_val), 0);
        chk("pstart_first", int'(bus.period_start), 1);
      end
      if (c == PER + 1)   chk("pstart_one_cycle", int'(bus.period_start), 0);
      if (c == 2 * PER)   chk("pstart_second", int'(bus.period_start), 1);
    end
    chk("pstart_count_two_periods", highs, 2);
    chk("idle_x", int'(bus.x_val), 1500);

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].send) send(tbl[i].data);
      boundary_then_x($sformatf("vec%0d_x", i), tbl[i].exp_x);
      chk($sformatf("vec%0d_ready", i), int'(bus.sample_ready), 1);
    end

    // stall: 400 accepted, 600 held through the boundary, taken one clk later
    send(10'd400);
    repeat (3) @(negedge clk);
    bus.sample_valid = 1'b1;
    bus.sample_data  = 10'd600;
    @(negedge clk);
    chk("stall_ready", int'(bus.sample_ready), 0);
    wait_pstart(n);
    chk("ready_on_boundary", int'(bus.sample_ready), 0);
    @(negedge clk);
    chk("ready_after_boundary", int'(bus.sample_ready), 1);
    chk("stall_x_b1", int'(bus.x_val), 2000);
    @(negedge clk);
    bus.sample_valid = 1'b0;
    chk("second_accepted", int'(bus.sample_ready), 0);
    boundary_then_x("stall_x_b2", 1950);
    for (int k = 1; k <= 7; k++) boundary_then_x("stall_ramp", 1950 - 50 * k);
    boundary_then_x("stall_hold", 1600);

    // reset mid-ramp 1500->2000 at x=1700 with a sample still pending
    async_reset_check("rst_pre");
    send(10'd1023);
    boundary_then_x("mr_b1", 1500);
    for (int k = 1; k <= 4; k++) boundary_then_x("mr_ramp", 1500 + 50 * k);
    send(10'd500);
    repeat (5) @(negedge clk);
    async_reset_check("rst_mid");
    wait_pstart(n);
    chk("first_pstart_after_reset", n, PER);
    @(negedge clk);
    chk("mr_no_resume_1", int'(bus.x_val), 1500);
    boundary_then_x("mr_no_resume_2", 1500);
    boundary_then_x("mr_no_resume_3", 1500);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/servo_setpoint_timebase.md
Name: servo_setpoint_timebase

Overview:
Upstream stage of the per-axis PWM comparator. It generates the shared PWM period counter, 0..2999 at 1 count/µs, giving a 3 ms period. It also turns raw SPI joystick samples into the slew-limited 11-bit pulse-width setpoint, 1000..2000 µs. The comparator consumes cntr_val and x_val directly and asserts PWM while cntr_val < x_val.

Parameters:
CLK_DIV, 100, clk cycles per counter tick (100 MHz → 1 µs)
PERIOD_CNT, 3000, counter modulus (3 ms period)
MIN_PULSE, 1000, offset added to the clamped sample (1 ms)
MAX_IN, 1000, saturation limit for the raw sample
CENTER, 1500, neutral setpoint used at reset
SLEW_STEP, 50, maximum x_val change per PWM period

Ports:
clk  in  1  system clock, 100 MHz
rst  in  1  asynchronous, active-high reset
sample_valid  in  1  SPI sample valid
sample_data  in  10  raw joystick axis value, 0..1023
sample_ready  out  1  block can accept a sample
cntr_val  out  12  PWM period counter, 0..PERIOD_CNT-1
x_val  out  11  pulse-width setpoint, MIN_PULSE..MIN_PULSE+MAX_IN
period_start  out  1  one-cycle pulse in the first clk after cntr_val wraps to 0

Behaviour:
- Reset: one clock domain; rst is asynchronous and active-high and clears all state immediately.
  - Reset values: prescaler 0, cntr_val 0, period_start 0, pending_full 0 (so sample_ready 1), target CENTER, x_val CENTER.
- Prescaler:
  - Counts 0..CLK_DIV-1. tick is asserted in the cycle the prescaler equals CLK_DIV-1; the prescaler then wraps to 0.
- Period counter:
  - On tick, cntr_val increments. At PERIOD_CNT-1 it wraps to 0, and on that same edge period_start is registered to 1.
  - period_start is high for exactly one clk. The full period is CLK_DIV*PERIOD_CNT = 300000 clk.
- Sample intake (valid/ready):
  - sample_ready = !pending_full, combinational from the register.
  - A transfer occurs on an edge where sample_valid && sample_ready. On that edge: pending <= min(sample_data, MAX_IN) + MIN_PULSE, computed at 11 bits with no overflow possible, and pending_full <= 1.
  - While pending_full is set, further samples stall (ready low). The source must hold valid/data until ready.
- Period boundary (cycle with period_start==1):
  - x_val steps toward the old target:
    - if target > x_val, x_val += min(SLEW_STEP, target-x_val);
    - if target < x_val, x_val -= min(SLEW_STEP, x_val-target);
    - if equal, x_val is unchanged.
  - In the same cycle, if pending_full: target <= pending and pending_full <= 0.
  - A new sample therefore starts moving x_val at the next boundary.
  - A sample offered on the boundary cycle while pending_full is still 1 is not accepted (ready low). It is accepted one clk later.
- Hold between boundaries:
  - x_val changes only on boundary cycles, so it is stable for the whole PWM period.
  - The change lands while cntr_val==0 < MIN_PULSE ≤ x_val, so the comparator output does not glitch.
- Value range:
  - x_val never leaves [MIN_PULSE, MIN_PULSE+MAX_IN]; no underflow or overflow is possible.
  - Slew arithmetic uses 12-bit signed differences.
- Reset mid-operation: an in-flight sample is discarded, cntr_val returns to 0, and x_val returns to CENTER. The first period_start after release comes 300000 clk later.

Decomposition:
- servo_pkg holds:
  - the parameter defaults as localparams: CLK_DIV, PERIOD_CNT, MIN_PULSE, MAX_IN, CENTER, SLEW_STEP;
  - width constants CNTR_W=12 and SETPT_W=11;
  - typedefs cntr_t and setpt_t, shared with the PWM comparators.
- One sub-module: servo_timebase. It contains the prescaler, cntr_val and period_start. Its instance feeds both this block's slew logic and every axis comparator.

Test Plan:
- Reset/idle: assert rst asynchronously mid-cycle → cntr_val=0, x_val=1500, sample_ready=1, period_start=0 immediately; no samples applied → x_val stays 1500 forever.
- Timebase: free-run after reset → cntr_val increments every 100 clk, wraps 2999→0; period_start pulses once per 300000 clk, one cycle wide, in the clk after cntr_val becomes 0.
- Clamp and slew up: sample 1023 accepted → target 2000 at the next boundary; x_val goes 1550, 1600 … 2000 on the 10 following boundaries, then holds.
- Slew down and partial step: from x_val=2000 send sample 0 → x_val drops in steps of 50 to 1000. Then send 30 → target 1030, and x_val reaches 1030 in a single step of 30.
- Handshake stall: two samples (400, 600) presented back-to-back within one period → the first is accepted, the second stalls with sample_ready=0 until the clk after period_start. The bench also places a valid exactly on the boundary cycle → it is accepted one clk later. The final target is 1600.
- Reset mid-ramp: rst during a ramp 1500→2000 at x_val=1700 → x_val=1500 and cntr_val=0 at once; the pending sample is dropped and the ramp does not resume.
